// File: rtl/simple_maxpool_col_unit_if.sv
// Row-in / pooled-row-out bus of the column max-pool unit.
// Lane k of a row is element [k], each lane TIME_STEPS spike bits wide.
`ifndef IMG_WIDTH
`define IMG_WIDTH 8
`endif
`ifndef TIME_STEPS
`define TIME_STEPS 4
`endif

interface simple_maxpool_col_unit_if;
  logic                                    i_row_valid;
  logic [`IMG_WIDTH-1:0][`TIME_STEPS-1:0]  i_row_data;
  logic                                    o_pool_valid;
  logic [`IMG_WIDTH-1:0][`TIME_STEPS-1:0]  o_pool_data;
  logic                                    o_ch_done;
  logic                                    o_layer_done;

  modport master (output i_row_valid, i_row_data,
                  input  o_pool_valid, o_pool_data, o_ch_done, o_layer_done);
  modport slave  (input  i_row_valid, i_row_data,
                  output o_pool_valid, o_pool_data, o_ch_done, o_layer_done);
endinterface

// File: rtl/simple_maxpool_col_unit.sv
// Vertical 3-row / stride-2 spike max-pool with channel and layer tracking.
// Optional feature macro: MAXPOOL_COL_SPIKE_CNT_EN (adds saturating o_spike_cnt).
`ifndef IMG_WIDTH
`define IMG_WIDTH 8
`endif
`ifndef TIME_STEPS
`define TIME_STEPS 4
`endif

module simple_maxpool_col_unit (
  input  logic                         s_clk,
  input  logic                         s_rst_n,
  input  logic                         code_valid,
  input  logic [15:0]                  conv_in_ch,
  input  logic [15:0]                  conv_img_size,
  simple_maxpool_col_unit_if.slave     bus,
  output logic                         o_busy
`ifdef MAXPOOL_COL_SPIKE_CNT_EN
  ,
  output logic [31:0]                  o_spike_cnt
`endif
);
  localparam int W  = `IMG_WIDTH;
  localparam int T  = `TIME_STEPS;
  localparam int DW = W * T;

  typedef logic [W-1:0][T-1:0] row_t;
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_size, r_in_ch, r_row, r_ch;
  row_t        r_carry, r_acc;

  logic w_cfg_ok, w_acc, w_last_row, w_last_ch;

  assign w_cfg_ok   = (conv_img_size[15:1] != 15'd0) && (conv_in_ch != 16'd0);
  // A row arriving alongside the final layer_done pulse belongs to no layer.
  assign w_acc      = (r_state == S_RUN) && bus.i_row_valid && !code_valid && !bus.o_layer_done;
  assign w_last_row = (r_row == r_size - 16'd1);
  assign w_last_ch  = (r_ch == r_in_ch - 16'd1);

  always_ff @(posedge s_clk) begin
    if (!s_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (code_valid)                                 w_state_nxt = w_cfg_ok ? S_RUN : S_IDLE;
    else if (r_state == S_RUN && bus.o_layer_done)  w_state_nxt = S_IDLE;
  end

  always_comb begin
    o_busy = (r_state == S_RUN);
  end

  always_ff @(posedge s_clk) begin
    if (!s_rst_n) begin
      r_size           <= '0;
      r_in_ch          <= '0;
      r_row            <= '0;
      r_ch             <= '0;
      r_carry          <= '0;
      r_acc            <= '0;
      bus.o_pool_valid <= 1'b0;
      bus.o_pool_data  <= '0;
      bus.o_ch_done    <= 1'b0;
      bus.o_layer_done <= 1'b0;
    end else begin
      bus.o_pool_valid <= 1'b0;
      bus.o_ch_done    <= 1'b0;
      bus.o_layer_done <= 1'b0;
      if (code_valid) begin
        r_size  <= conv_img_size & 16'hFFFE;
        r_in_ch <= conv_in_ch;
        r_row   <= '0;
        r_ch    <= '0;
        r_carry <= '0;
        r_acc   <= '0;
      end else if (w_acc) begin
        if (!r_row[0]) begin
          r_acc <= r_carry | bus.i_row_data;
        end else begin
          bus.o_pool_data  <= r_acc | bus.i_row_data;
          bus.o_pool_valid <= 1'b1;
          r_carry          <= bus.i_row_data;
        end
        // Size is even, so the last row is always an emitting (odd) row.
        if (w_last_row) begin
          r_row         <= '0;
          r_carry       <= '0;
          r_ch          <= r_ch + 16'd1;
          bus.o_ch_done <= 1'b1;
          if (w_last_ch) bus.o_layer_done <= 1'b1;
        end else begin
          r_row <= r_row + 16'd1;
        end
      end
    end
  end

`ifdef MAXPOOL_COL_SPIKE_CNT_EN
  localparam int PW = $clog2(DW + 1);
  logic [DW-1:0] w_flat;
  logic [PW-1:0] w_pop;
  logic [32:0]   w_sum;

  assign w_flat = bus.o_pool_data;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < DW; i++) w_pop = w_pop + PW'(w_flat[i]);
  end

  assign w_sum = {1'b0, o_spike_cnt} + 33'(w_pop);

  always_ff @(posedge s_clk) begin
    if (!s_rst_n || code_valid) o_spike_cnt <= '0;
    else if (bus.o_pool_valid)  o_spike_cnt <= w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
  end
`endif

endmodule

// File: tb/tb_simple_maxpool_col_unit.sv
// Directed bench for simple_maxpool_col_unit: hand-computed pooled rows and flags.
`ifndef IMG_WIDTH
`define IMG_WIDTH 8
`endif
`ifndef TIME_STEPS
`define TIME_STEPS 4
`endif

module tb_simple_maxpool_col_unit;
  localparam int DW = `IMG_WIDTH * `TIME_STEPS;

  logic        s_clk = 1'b0;
  logic        s_rst_n;
  logic        code_valid;
  logic [15:0] conv_in_ch, conv_img_size;
  logic        o_busy;
`ifdef MAXPOOL_COL_SPIKE_CNT_EN
  logic [31:0] o_spike_cnt;
`endif

  simple_maxpool_col_unit_if bus();

  simple_maxpool_col_unit dut (
    .s_clk         (s_clk),
    .s_rst_n       (s_rst_n),
    .code_valid    (code_valid),
    .conv_in_ch    (conv_in_ch),
    .conv_img_size (conv_img_size),
    .bus           (bus.slave),
    .o_busy        (o_busy)
`ifdef MAXPOOL_COL_SPIKE_CNT_EN
    ,
    .o_spike_cnt   (o_spike_cnt)
`endif
  );

  always #5 s_clk = ~s_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  task automatic code(input logic [15:0] size, input logic [15:0] ch, input logic with_row);
    code_valid      = 1'b1;
    conv_img_size   = size;
    conv_in_ch      = ch;
    bus.i_row_valid = with_row;
    bus.i_row_data  = {DW{1'b1}};
    tick();
    code_valid      = 1'b0;
    bus.i_row_valid = 1'b0;
  endtask

  task automatic row(input logic [DW-1:0] d);
    bus.i_row_valid = 1'b1;
    bus.i_row_data  = d;
    tick();
    bus.i_row_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d,
                         input logic cd, input logic ld);
    chk({tag, ".valid"}, 64'(bus.o_pool_valid), 64'(v));
    if (v) chk({tag, ".data"}, 64'(bus.o_pool_data), 64'(d));
    chk({tag, ".ch_done"}, 64'(bus.o_ch_done), 64'(cd));
    chk({tag, ".layer_done"}, 64'(bus.o_layer_done), 64'(ld));
  endtask

  initial begin
    s_rst_n         = 1'b0;
    code_valid      = 1'b0;
    conv_in_ch      = '0;
    conv_img_size   = '0;
    bus.i_row_valid = 1'b0;
    bus.i_row_data  = '0;
    tick(); tick();

    // reset state
    chk("rst.valid", 64'(bus.o_pool_valid), 64'd0);
    chk("rst.data", 64'(bus.o_pool_data), 64'd0);
    chk("rst.ch_done", 64'(bus.o_ch_done), 64'd0);
    chk("rst.layer_done", 64'(bus.o_layer_done), 64'd0);
    chk("rst.busy", 64'(o_busy), 64'd0);
`ifdef MAXPOOL_COL_SPIKE_CNT_EN
    chk("rst.spike_cnt", 64'(o_spike_cnt), 64'd0);
`endif
    s_rst_n = 1'b1;
    tick();

    // rows before any code are ignored
    row(32'h1); chk_out("idle.r0", 1'b0, '0, 1'b0, 1'b0);
    row(32'h2); chk_out("idle.r1", 1'b0, '0, 1'b0, 1'b0);
    chk("idle.busy", 64'(o_busy), 64'd0);

    // basic 4-row pool
    code(16'd4, 16'd1, 1'b0);
    chk("basic.busy_up", 64'(o_busy), 64'd1);
    row(32'h1); chk_out("basic.r0", 1'b0, '0, 1'b0, 1'b0);
    row(32'h2); chk_out("basic.r1", 1'b1, 32'h3, 1'b0, 1'b0);
    row(32'h4); chk_out("basic.r2", 1'b0, '0, 1'b0, 1'b0);
    row(32'h8); chk_out("basic.r3", 1'b1, 32'hE, 1'b1, 1'b1);
    chk("basic.busy_at_done", 64'(o_busy), 64'd1);
    tick();
    chk("basic.busy_down", 64'(o_busy), 64'd0);
    chk("basic.valid_gone", 64'(bus.o_pool_valid), 64'd0);
    chk("basic.data_hold", 64'(bus.o_pool_data), 64'hE);
`ifdef MAXPOOL_COL_SPIKE_CNT_EN
    chk("spike.basic", 64'(o_spike_cnt), 64'd5);
`endif

    // channel carry reset between channels
    code(16'd4, 16'd2, 1'b0);
`ifdef MAXPOOL_COL_SPIKE_CNT_EN
    chk("spike.cleared", 64'(o_spike_cnt), 64'd0);
`endif
    row(32'h0); row(32'h0); chk_out("carry.c0o0", 1'b1, 32'h0, 1'b0, 1'b0);
    row(32'h0); row(32'hF); chk_out("carry.c0o1", 1'b1, 32'hF, 1'b1, 1'b0);
    row(32'h0); row(32'h0); chk_out("carry.c1o0", 1'b1, 32'h0, 1'b0, 1'b0);
    row(32'h0); row(32'h0); chk_out("carry.c1o1", 1'b1, 32'h0, 1'b1, 1'b1);
    tick();
    chk("carry.busy_down", 64'(o_busy), 64'd0);

    // back-to-back rows, size 8: row r is all ones in lane r
    code(16'd8, 16'd1, 1'b0);
    begin
      logic [DW-1:0] exp_o [4];
      exp_o[0] = 32'h0000_00FF;
      exp_o[1] = 32'h0000_FFF0;
      exp_o[2] = 32'h00FF_F000;
      exp_o[3] = 32'hFFF0_0000;
      for (int r = 0; r < 8; r++) begin
        row(DW'(32'hF) << (4 * r));
        if (r[0]) chk_out($sformatf("b2b.o%0d", r / 2), 1'b1, exp_o[r / 2], r == 7, r == 7);
        else      chk_out($sformatf("b2b.r%0d", r), 1'b0, '0, 1'b0, 1'b0);
      end
    end

    // code_valid coincident with a row drops that row
    code(16'd4, 16'd1, 1'b1);
    row(32'h1); chk_out("prio.r0", 1'b0, '0, 1'b0, 1'b0);
    row(32'h2); chk_out("prio.r1", 1'b1, 32'h3, 1'b0, 1'b0);
    row(32'h0); row(32'h0); chk_out("prio.r3", 1'b1, 32'h2, 1'b1, 1'b1);
    tick();

    // illegal layer codes keep the block idle
    code(16'd0, 16'd1, 1'b0); chk("bad.size0", 64'(o_busy), 64'd0);
    code(16'd1, 16'd1, 1'b0); chk("bad.size1", 64'(o_busy), 64'd0);
    code(16'd4, 16'd0, 1'b0); chk("bad.ch0", 64'(o_busy), 64'd0);
    row(32'h1); row(32'h2); chk_out("bad.rows", 1'b0, '0, 1'b0, 1'b0);

    // reset mid-layer, then a fresh layer pools from row 0
    code(16'd8, 16'd1, 1'b0);
    row(32'h1); row(32'h2); chk_out("mid.o0", 1'b1, 32'h3, 1'b0, 1'b0);
    row(32'h4);
    s_rst_n = 1'b0;
    tick();
    chk("mid.rst.data", 64'(bus.o_pool_data), 64'd0);
    chk("mid.rst.valid", 64'(bus.o_pool_valid), 64'd0);
    chk("mid.rst.busy", 64'(o_busy), 64'd0);
    s_rst_n = 1'b1;
    code(16'd4, 16'd1, 1'b0);
    row(32'h10); row(32'h20); chk_out("mid.new.o0", 1'b1, 32'h30, 1'b0, 1'b0);
    row(32'h40); row(32'h80); chk_out("mid.new.o1", 1'b1, 32'hE0, 1'b1, 1'b1);
    tick();
    chk("mid.new.busy_down", 64'(o_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
